// File: rtl/somador_serial_if.sv
// Requester and full-adder signals of the bit-serial adder controller.
// start/done: start is taken only while idle; done pulses once when sum/cout/ovf are valid.
interface somador_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;

    modport master (
        output start, op_a, op_b, cin, fa_s, fa_cout,
        input  busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin
    );

    modport slave (
        input  start, op_a, op_b, cin, fa_s, fa_cout,
        output busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin
    );
endinterface

// File: rtl/somador_serial.sv
// Bit-serial WIDTH-bit adder controller: drives one external full adder LSB first
// over WIDTH cycles and registers sum, carry-out and signed overflow.
module somador_serial #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    somador_serial_if.slave bus,
    output logic [1:0]      state_dbg
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;

    assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.fa_a   = 1'b0;
        bus.fa_b   = 1'b0;
        bus.fa_cin = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                bus.busy   = 1'b1;
                bus.fa_a   = a_sr[0];
                bus.fa_b   = b_sr[0];
                bus.fa_cin = carry_q;
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at position 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr    <= bus.op_a;
                        b_sr    <= bus.op_b;
                        carry_q <= bus.cin;
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    s_sr    <= {bus.fa_s, s_sr[WIDTH-1:1]};
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    carry_q <= bus.fa_cout;
                    if (last_bit) begin
                        sum_q  <= {bus.fa_s, s_sr[WIDTH-1:1]};
                        cout_q <= bus.fa_cout;
                        ovf_q  <= carry_q ^ bus.fa_cout;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: WIDTH=8 directed/random tests and a WIDTH=2 sweep,
// with a behavioural full adder and an arithmetic reference model.
module tb_somador_serial;
    logic       clk;
    logic       rst;
    logic [1:0] state_dbg8;
    logic [1:0] state_dbg2;
    int         n_cmp;
    int         n_err;
    logic [9:0] exp_q[$];

    somador_serial_if #(.WIDTH(8)) bus8 ();
    somador_serial_if #(.WIDTH(2)) bus2 ();

    somador_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave), .state_dbg(state_dbg8)
    );
    somador_serial #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave), .state_dbg(state_dbg2)
    );

    // External full adders
    assign bus8.fa_s    = bus8.fa_a ^ bus8.fa_b ^ bus8.fa_cin;
    assign bus8.fa_cout = (bus8.fa_a & bus8.fa_b) | (bus8.fa_cin & (bus8.fa_a ^ bus8.fa_b));
    assign bus2.fa_s    = bus2.fa_a ^ bus2.fa_b ^ bus2.fa_cin;
    assign bus2.fa_cout = (bus2.fa_a & bus2.fa_b) | (bus2.fa_cin & (bus2.fa_a ^ bus2.fa_b));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: {ovf, cout, sum} from integer arithmetic.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int u;
        int sv;
        u  = int'(a) + int'(b) + int'(c);
        sv = (a[7] ? int'(a) - 256 : int'(a)) + (b[7] ? int'(b) - 256 : int'(b)) + int'(c);
        return {(sv > 127 || sv < -128), u[8], u[7:0]};
    endfunction

    function automatic logic [3:0] model2(input logic [1:0] a, input logic [1:0] b, input logic c);
        int u;
        int sv;
        u  = int'(a) + int'(b) + int'(c);
        sv = (a[1] ? int'(a) - 4 : int'(a)) + (b[1] ? int'(b) - 4 : int'(b)) + int'(c);
        return {1'b0, (sv > 1 || sv < -2), u[2], u[1:0]};
    endfunction

    // Drivers: pulse start for one cycle, then watch until done (bounded).
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output logic [9:0] res, output int lat, output int busy_n,
                          output bit stable);
        logic [9:0] r0;
        @(negedge clk);
        bus8.op_a  = a;
        bus8.op_b  = b;
        bus8.cin   = c;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        r0     = {bus8.ovf, bus8.cout, bus8.sum};
        lat    = 1;
        busy_n = 0;
        stable = 1'b1;
        forever begin
            if (bus8.busy) busy_n++;
            if (bus8.done) break;
            if ({bus8.ovf, bus8.cout, bus8.sum} !== r0) stable = 1'b0;
            if (lat >= 50) begin
                lat = -1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        res = {bus8.ovf, bus8.cout, bus8.sum};
    endtask

    task automatic do_op2(input logic [1:0] a, input logic [1:0] b, input logic c,
                          output logic [3:0] res, output int lat);
        @(negedge clk);
        bus2.op_a  = a;
        bus2.op_b  = b;
        bus2.cin   = c;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        lat = 1;
        while (!bus2.done) begin
            if (lat >= 20) begin
                lat = -1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        res = {1'b0, bus2.ovf, bus2.cout, bus2.sum};
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus8.start = 1'b1;
        bus8.op_a  = 8'hA5;
        bus8.op_b  = 8'h5A;
        bus8.cin   = 1'b1;
        bus2.start = 1'b1;
        bus2.op_a  = 2'b11;
        bus2.op_b  = 2'b11;
        bus2.cin   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum} !== 12'h000) begin
                n_err++;
                $display("FAIL reset_out8: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                         bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum);
            end
            n_cmp++;
            if ({bus8.fa_a, bus8.fa_b, bus8.fa_cin} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_fa8: got %b, want 000", {bus8.fa_a, bus8.fa_b, bus8.fa_cin});
            end
            n_cmp++;
            if ({bus2.busy, bus2.done, bus2.cout, bus2.ovf, bus2.sum} !== 6'h00) begin
                n_err++;
                $display("FAIL reset_out2: got busy=%b done=%b sum=%h, want 0",
                         bus2.busy, bus2.done, bus2.sum);
            end
        end
        rst        = 1'b0;
        bus8.start = 1'b0;
        bus2.start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus8.busy !== 1'b0 || bus2.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_accept: got busy8=%b busy2=%b, want 0 0", bus8.busy, bus2.busy);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] r;
        int lat, bn;
        bit st;
        do_op8(8'h5A, 8'h3C, 1'b0, r, lat, bn, st);
        n_cmp++;
        if (lat != 9) begin
            n_err++;
            $display("FAIL ovf_latency: got %0d, want 9", lat);
        end
        n_cmp++;
        if (bn != 9) begin
            n_err++;
            $display("FAIL ovf_busy_cycles: got %0d, want 9", bn);
        end
        n_cmp++;
        if (r !== {1'b1, 1'b0, 8'h96}) begin
            n_err++;
            $display("FAIL ovf_result: got ovf=%b cout=%b sum=%h, want 1 0 96", r[9], r[8], r[7:0]);
        end
        n_cmp++;
        if (!st) begin
            n_err++;
            $display("FAIL ovf_stable: got result change during RUN, want stable");
        end
        @(negedge clk);
        n_cmp++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.sum !== 8'h96) begin
            n_err++;
            $display("FAIL ovf_after_done: got done=%b busy=%b sum=%h, want 0 0 96",
                     bus8.done, bus8.busy, bus8.sum);
        end
    endtask

    task automatic test_carry();
        logic [7:0] ta [2];
        logic [7:0] tb [2];
        logic       tc [2];
        logic [9:0] r;
        int lat, bn;
        bit st;
        ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0;
        ta[1] = 8'hFF; tb[1] = 8'h00; tc[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_op8(ta[i], tb[i], tc[i], r, lat, bn, st);
            n_cmp++;
            if (r !== {1'b0, 1'b1, 8'h00} || lat != 9) begin
                n_err++;
                $display("FAIL carry_%0d: got ovf=%b cout=%b sum=%h lat=%0d, want 0 1 00 lat=9",
                         i, r[9], r[8], r[7:0], lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] r;
        int lat, bn;
        bit st;
        do_op8(8'h80, 8'h80, 1'b0, r, lat, bn, st);
        n_cmp++;
        if (r !== {1'b1, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL b2b_first: got ovf=%b cout=%b sum=%h, want 1 1 00", r[9], r[8], r[7:0]);
        end
        do_op8(8'h7F, 8'h01, 1'b0, r, lat, bn, st);
        n_cmp++;
        if (lat != 9) begin
            n_err++;
            $display("FAIL b2b_accept: got latency %0d, want 9", lat);
        end
        n_cmp++;
        if (r !== {1'b1, 1'b0, 8'h80}) begin
            n_err++;
            $display("FAIL b2b_second: got ovf=%b cout=%b sum=%h, want 1 0 80", r[9], r[8], r[7:0]);
        end
    endtask

    task automatic test_isolation();
        int done_n;
        logic [7:0] s;
        logic [9:0] r;
        int lat, bn;
        bit st;
        s = 8'h00;
        @(negedge clk);
        bus8.op_a  = 8'h11;
        bus8.op_b  = 8'h22;
        bus8.cin   = 1'b0;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        bus8.op_a  = 8'hFF;
        bus8.op_b  = 8'hFF;
        bus8.cin   = 1'b1;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        done_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus8.done) begin
                done_n++;
                if (done_n == 1) s = bus8.sum;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done_n != 1) begin
            n_err++;
            $display("FAIL iso_done_count: got %0d, want 1", done_n);
        end
        n_cmp++;
        if (s !== 8'h33) begin
            n_err++;
            $display("FAIL iso_sum: got %h, want 33", s);
        end

        bus8.op_a  = 8'h40;
        bus8.op_b  = 8'h40;
        bus8.cin   = 1'b0;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum} !== 12'h000) begin
            n_err++;
            $display("FAIL iso_reset_out: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                     bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum);
        end
        done_n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus8.done) done_n++;
        end
        n_cmp++;
        if (done_n != 0 || bus8.busy !== 1'b0) begin
            n_err++;
            $display("FAIL iso_reset_nodone: got done_count=%0d busy=%b, want 0 0", done_n, bus8.busy);
        end
        do_op8(8'h01, 8'h02, 1'b0, r, lat, bn, st);
        n_cmp++;
        if (r !== {1'b0, 1'b0, 8'h03}) begin
            n_err++;
            $display("FAIL iso_fresh: got ovf=%b cout=%b sum=%h, want 0 0 03", r[9], r[8], r[7:0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic c;
        logic [9:0] r, e;
        int lat, bn;
        bit st;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            exp_q.push_back(model8(a, b, c));
            do_op8(a, b, c, r, lat, bn, st);
            e = exp_q.pop_front();
            n_cmp++;
            if (r !== e || lat != 9) begin
                n_err++;
                $display("FAIL random_%0d: %h+%h+%b got ovf=%b cout=%b sum=%h lat=%0d, want %b %b %h lat=9",
                         i, a, b, c, r[9], r[8], r[7:0], lat, e[9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_sweep2();
        logic [3:0] r, e;
        int lat;
        for (int k = 0; k < 32; k++) begin
            e = model2(2'(k >> 3), 2'(k >> 1), 1'(k));
            do_op2(2'(k >> 3), 2'(k >> 1), 1'(k), r, lat);
            n_cmp++;
            if (r !== e || lat != 3) begin
                n_err++;
                $display("FAIL sweep2_%0d: got ovf=%b cout=%b sum=%b lat=%0d, want %b %b %b lat=3",
                         k, r[2], r[1], r[0 +: 2], lat, e[2], e[1], e[0 +: 2]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        test_reset();
        test_overflow();
        test_carry();
        test_back_to_back();
        test_isolation();
        test_random();
        test_sweep2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/somador_serial.md
# somador_serial

Bit-serial N-bit adder controller. It time-multiplexes one external `somador1bit` full adder over `WIDTH` clock cycles, LSB first, to produce an N-bit sum with carry-out and signed overflow. It sits between a requester using a start/done handshake and the single-bit adder datapath, and owns all sequencing state: operand shift registers, carry flip-flop, bit counter and result register.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range ≥ 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request; sampled only in IDLE.
- `op_a`  in  WIDTH: operand A, captured when `start` is accepted.
- `op_b`  in  WIDTH: operand B, captured when `start` is accepted.
- `cin`  in  1: carry-in, captured when `start` is accepted.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse; result valid.
- `sum`  out  WIDTH: registered result; holds until the next `done`.
- `cout`  out  1: registered carry-out of the MSB.
- `ovf`  out  1: registered signed overflow, defined as carry into the MSB XOR carry out of the MSB.
- `fa_a`  out  1: drives the full-adder `a` input.
- `fa_b`  out  1: drives the full-adder `b` input.
- `fa_cin`  out  1: drives the full-adder `cin` input.
- `fa_s`  in  1: full-adder sum, combinational return.
- `fa_cout`  in  1: full-adder carry, combinational return.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- **IDLE, with `start`=1:**
  - Load `a_sr`←`op_a`, `b_sr`←`op_b` and `carry_q`←`cin`.
  - Clear `bit_cnt` to 0.
  - Go to RUN.
- **IDLE, with `start`=0:** stay in IDLE.
- **RUN, datapath drive:** the full adder is driven directly from registers.
  - `fa_a`=`a_sr[0]`, `fa_b`=`b_sr[0]`, `fa_cin`=`carry_q`.
- **RUN, each rising edge:**
  - `s_sr` ← {`fa_s`, `s_sr[WIDTH-1:1]`} (sum bits shift in at the MSB).
  - `a_sr` and `b_sr` shift right by one.
  - `carry_q` ← `fa_cout`.
  - `bit_cnt` increments.
- **RUN, last bit (`bit_cnt`==WIDTH-1):**
  - `sum` ← {`fa_s`, `s_sr[WIDTH-1:1]`}.
  - `cout` ← `fa_cout`.
  - `ovf` ← `fa_cin` XOR `fa_cout`.
  - Go to DONE.
- **DONE:** `done`=1 for exactly this cycle, then go to IDLE unconditionally.
- **`fa_a`/`fa_b`/`fa_cin` outside RUN:** driven 0.
- **Operand capture:**
  - Operands are captured only on acceptance.
  - Changes on `op_a`, `op_b` or `cin` while busy have no effect.
- **`start` while busy:** ignored, including during the DONE cycle. It is not queued; the requester re-asserts `start` in IDLE.
- **Arithmetic:** unsigned modulo 2^WIDTH. {`cout`,`sum`} = `op_a` + `op_b` + `cin`.
- **`bit_cnt` width:** $clog2(WIDTH) bits. No wrap-around occurs: the exit happens at WIDTH-1.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0. `fa_a`, `fa_b` and `fa_cin` are 0. All internal registers are 0.
- **Reset mid-operation:** `rst`=1 at any edge aborts the operation. All outputs take their reset values the next cycle. No `done` is produced.
- **Latency:**
  - `start` sampled at edge E0.
  - RUN covers edges E1..E_WIDTH.
  - `done`=1 during the cycle after E_WIDTH, i.e. WIDTH+1 cycles after acceptance.
- **`busy` window:** rises the cycle after E0 and falls together with `done`.
- **Back-to-back operation:** the earliest next acceptance is the cycle after `done`. Throughput is one operation per WIDTH+2 cycles.
- **Result stability:** `sum`, `cout` and `ovf` change only at the edge entering DONE. They are stable while `done`=1 and afterwards.
- **Full-adder path:** the full adder is purely combinational. The single-cycle path runs `carry_q` → `fa_cin` → adder → `fa_cout` → `carry_q`.

## Test plan
- **Reset behaviour:** hold `rst` for 2 cycles with `start`=1 → all outputs are 0, `busy`=0, and no acceptance occurs while `rst`=1.
- **Signed overflow (WIDTH=8):**
  - Stimulus: `op_a`=0x5A, `op_b`=0x3C, `cin`=0, one-cycle `start`.
  - Response: `done` 9 cycles later with `sum`=0x96, `cout`=0, `ovf`=1.
  - `busy` is high for exactly 9 cycles.
- **Carry without overflow and with carry-in:**
  - 0xFF+0x01, `cin`=0 → `sum`=0x00, `cout`=1, `ovf`=0.
  - 0xFF+0x00, `cin`=1 → `sum`=0x00, `cout`=1, `ovf`=0.
- **Both-MSB overflow:** 0x80+0x80, `cin`=0 → `sum`=0x00, `cout`=1, `ovf`=1.
  - Then 0x7F+0x01 → `sum`=0x80, `cout`=0, `ovf`=1.
  - Issue the second operation on the cycle after the first `done` → it is accepted.
- **Input isolation:**
  - Change `op_a` and pulse `start` during RUN cycle 3 → result is unaffected and no second `done` appears.
  - Assert `rst` during RUN cycle 3 → outputs return to 0 and no `done` appears.
  - A fresh 0x01+0x02 afterwards → `sum`=0x03.
- **Exhaustive sweep:** WIDTH=2, all 32 combinations of {`op_a`,`op_b`,`cin`} → {`cout`,`sum`} matches `op_a`+`op_b`+`cin`, and `ovf` matches the signed rule. The counts of tests and errors are reported.
